// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - 32-bit store value to 16-bit big-endian data-memory beats
// Word stores take two beats; ovf flags values that signed narrowing would not preserve.
module store_narrower #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              ovf,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state, state_n;
  logic              is_word, is_word_n;
  logic [15:0]       lo_half, lo_half_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_n;
  logic [1:0]        be_n;
  logic              ovf_n, done_n, err_n;
  logic              accept, bad_req, fits_byte, fits_half;

  assign in_ready  = reset_n & (state == IDLE);
  assign mem_valid = (state != IDLE);
  assign accept    = in_valid & in_ready;

  assign bad_req = (in_size == 2'b11) ||
                   ((in_size == 2'b01) && in_addr[0]) ||
                   ((in_size == 2'b10) && (in_addr[1:0] != 2'b00));

  // Value fits when every bit above the narrowed sign bit equals that sign bit.
  assign fits_byte = (&in_data[31:7])  | ~(|in_data[31:7]);
  assign fits_half = (&in_data[31:15]) | ~(|in_data[31:15]);

  always_comb begin
    state_n   = state;
    is_word_n = is_word;
    lo_half_n = lo_half;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    be_n      = mem_be;
    ovf_n     = ovf;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            err_n = 1'b1;
            ovf_n = 1'b0;
          end else begin
            state_n   = BEAT0;
            addr_n    = {in_addr[ADDR_W-1:1], 1'b0};
            lo_half_n = in_data[15:0];
            is_word_n = (in_size == 2'b10);
            case (in_size)
              2'b00: begin
                wdata_n = {in_data[7:0], in_data[7:0]};
                be_n    = in_addr[0] ? 2'b01 : 2'b10;
                ovf_n   = ~fits_byte;
              end
              2'b01: begin
                wdata_n = in_data[15:0];
                be_n    = 2'b11;
                ovf_n   = ~fits_half;
              end
              default: begin
                wdata_n = in_data[31:16];
                be_n    = 2'b11;
                ovf_n   = 1'b0;
              end
            endcase
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (is_word) begin
            state_n = BEAT1;
            addr_n  = mem_addr + ADDR_W'(2);
            wdata_n = lo_half;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      is_word   <= 1'b0;
      lo_half   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      is_word   <= is_word_n;
      lo_half   <= lo_half_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_be    <= be_n;
      ovf       <= ovf_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_store_narrower.sv
// tb/tb_store_narrower.sv - randomized self-checking bench for store_narrower
// Expected beats and ovf come from a reference model built from address/size rules.
module tb_store_narrower;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [31:0]   in_data;
  logic [1:0]    in_size;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic          ovf, done, err;

  int total = 0;
  int nbad  = 0;

  always #5 clk = ~clk;

  store_narrower #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ovf(ovf), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rejected(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic bit model_ovf(input logic [31:0] d, input logic [1:0] s);
    int sd;
    sd = $signed(d);
    case (s)
      2'b00:   return (sd < -128) || (sd > 127);
      2'b01:   return (sd < -32768) || (sd > 32767);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
  endtask

  // Starts in an idle cycle, ends in the done/err cycle without advancing.
  // stalls < 0: random backpressure per beat; otherwise that many stalls on the first beat.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input int stalls);
    logic [31:0] qa[$];
    logic [15:0] qd[$];
    logic [1:0]  qb[$];
    bit          exp_o;
    int          st;
    bit          first;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    check("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    if (rejected(a, s)) begin
      check("err_pulse", err, 1);
      check("err_no_beat", mem_valid, 0);
      check("err_in_ready", in_ready, 1);
      check("err_ovf", ovf, 0);
      return;
    end
    case (s)
      2'b00: begin
        qa.push_back({a[31:1], 1'b0});
        qd.push_back({d[7:0], d[7:0]});
        qb.push_back(a[0] ? 2'b01 : 2'b10);
      end
      2'b01: begin
        qa.push_back(a); qd.push_back(d[15:0]); qb.push_back(2'b11);
      end
      default: begin
        qa.push_back(a);      qd.push_back(d[31:16]); qb.push_back(2'b11);
        qa.push_back(a + 2);  qd.push_back(d[15:0]);  qb.push_back(2'b11);
      end
    endcase
    exp_o = model_ovf(d, s);
    first = 1'b1;
    while (qa.size() > 0) begin
      if (stalls < 0) st = $urandom_range(0, 2);
      else            st = first ? stalls : 0;
      first = 1'b0;
      for (int k = 0; k <= st; k++) begin
        check("beat_valid", mem_valid, 1);
        check("beat_addr", mem_addr, qa[0]);
        check("beat_wdata", mem_wdata, qd[0]);
        check("beat_be", mem_be, qb[0]);
        check("beat_ovf", ovf, exp_o);
        check("beat_no_done", done, 0);
        check("beat_busy", in_ready, 0);
        mem_ready = (k == st);
        in_valid  = $urandom_range(0, 1);
        in_data   = $urandom;
        step();
      end
      in_valid = 1'b0;
      void'(qa.pop_front());
      void'(qd.pop_front());
      void'(qb.pop_front());
    end
    mem_ready = $urandom_range(0, 1);
    check("done_pulse", done, 1);
    check("done_no_valid", mem_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("done_ovf", ovf, exp_o);
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    mem_ready = $urandom_range(0, 1);
    step();
    check("idle_no_done", done, 0);
    check("idle_no_err", err, 0);
    check("idle_no_valid", mem_valid, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    logic [7:0]  b8;
    logic [15:0] b16;
    reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_size = '0;
    mem_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs();
    reset_n = 1'b1;
    step();
    check("post_reset_ready", in_ready, 1);

    do_store(32'h0000_1001, 32'h0000_00A5, 2'b00, 0);
    idle_cycle();
    do_store(32'h0000_2002, 32'hFFFF_8001, 2'b01, 0);
    idle_cycle();
    do_store(32'h0000_3000, 32'h1234_5678, 2'b10, 3);
    idle_cycle();
    do_store(32'h0000_4002, 32'hDEAD_BEEF, 2'b10, 0);
    do_store(32'h0000_4001, 32'h0000_0001, 2'b01, 0);
    do_store(32'h0000_4000, 32'h0000_0002, 2'b11, 0);
    idle_cycle();

    in_valid = 1'b1; in_addr = 32'h0000_5000; in_data = 32'hCAFE_F00D; in_size = 2'b10;
    mem_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("rst_mid_beat0", mem_addr, 32'h0000_5000);
    step();
    check("rst_mid_beat1", mem_addr, 32'h0000_5002);
    reset_n = 1'b0;
    mem_ready = 1'b0;
    step();
    check_reset_outputs();
    reset_n = 1'b1;
    step();
    check("rst_mid_no_done", done, 0);
    check("rst_mid_idle", mem_valid, 0);
    do_store(32'h0000_5003, 32'hFFFF_FF80, 2'b00, 0);
    idle_cycle();

    do_store(32'hFFFF_FFFC, 32'h89AB_CDEF, 2'b10, 0);
    do_store(32'h0000_6000, 32'h0000_7FFF, 2'b01, 0);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      b8  = 8'($urandom);
      b16 = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = {{24{b8[7]}}, b8};
        default: d = {{16{b16[15]}}, b16};
      endcase
      do_store(a, d, s, -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
